pipeline_run_ctrl: RTL and testbench
====================================

// Module: pipeline_run_ctrl
// PURPOSE
//   Run/step controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB latches, PC).
//   Decodes one-byte commands from the UART receiver and drives the global pipeline
//   enable and flush. On a HALT instruction or a break command it drains or freezes
//   the pipeline, then hands off to the UART debug dumper through a req/ack handshake.
//   Sits between the UART RX/TX debug path and the DataPath latch enables.
// PARAMETERS
//   CMD_RUN      8'h52  'R': free-run until HALT or break
//   CMD_STEP     8'h53  'S': advance the pipeline exactly one clock, then dump
//   CMD_BREAK    8'h42  'B': stop a free run immediately, then dump
//   CMD_CLEAR    8'h43  'C': flush latches/PC, clear cycle counter
//   DRAIN_CYCLES 4      pipe_en cycles after HALT fetched (lets WB retire); must be >= 1
//   CNT_W        32     width of cycle_count
// PORTS
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-high
//   rx_data       in   8      command byte from UART receiver
//   rx_valid      in   1      one-cycle strobe, rx_data valid
//   halt_fetched  in   1      ID stage holds HALT opcode; only meaningful while pipe_en=1
//   dump_ack      in   1      dumper finished sending state over tx
//   pipe_en       out  1      PC and all pipeline-latch write enable
//   pipe_flush    out  1      synchronous clear of PC and pipeline latches
//   dump_req      out  1      request register/memory dump over UART
//   busy          out  1      state != IDLE
//   state         out  3      current FSM state, for debug
//   cycle_count   out  CNT_W  clocks with pipe_en=1 since last reset/CLEAR
// BEHAVIOUR
//   Reset values: state=IDLE, pipe_en=0, pipe_flush=0, dump_req=0, busy=0,
//     cycle_count=0, drain counter=0. Assertion mid-operation aborts immediately.
//   Moore outputs: pipe_en, pipe_flush, dump_req and busy decode from the state
//     register only; no combinational input-to-output path.
//   States/encoding: IDLE=0 RUN=1 STEP=2 DRAIN=3 DUMP=4 FLUSH=5; 6,7 -> IDLE next clk.
//   IDLE : outputs 0. On rx_valid: CMD_RUN->RUN, CMD_STEP->STEP, CMD_CLEAR->FLUSH.
//          CMD_BREAK and unknown bytes are ignored.
//   RUN  : pipe_en=1. halt_fetched -> DRAIN, drain counter loaded DRAIN_CYCLES-1.
//          Else rx_valid & CMD_BREAK -> DUMP. Simultaneous halt+break: halt wins.
//          All other bytes are ignored.
//   STEP : pipe_en=1 for exactly one clock. Then halt_fetched -> DRAIN, else DUMP.
//   DRAIN: pipe_en=1. Counter decrements each clock; at 0 -> DUMP. Exactly
//          DRAIN_CYCLES clocks in DRAIN. halt_fetched and rx_valid are ignored.
//   DUMP : pipe_en=0, dump_req=1, held until dump_ack is sampled high -> IDLE.
//          dump_req drops the clock after ack. rx_valid is ignored (bytes dropped).
//   FLUSH: pipe_flush=1, pipe_en=0, for one clock; cycle_count<=0; -> IDLE.
//   cycle_count: +1 on every clock where pipe_en=1 (RUN, STEP, DRAIN).
//     Saturates at all-ones; no wrap.
//   Latency: command byte at clk n -> state change and pipe_en at clk n+1.
//   dump_ack outside DUMP is ignored.
// TESTING
//   1 reset, rx 'S' -> pipe_en high exactly 1 clk, cycle_count=1,
//     dump_req high until ack, then IDLE.
//   2 'R', halt_fetched pulsed after 10 run clks -> 10 + 4 pipe_en clks
//     (cycle_count=14), then dump_req.
//   3 'R', then 'B' after 7 clks -> DUMP next clk, no drain, cycle_count=7.
//   4 RUN with halt_fetched and 'B' on same clk -> DRAIN taken (4 clks), then DUMP.
//   5 'C' after activity -> pipe_flush one clk, cycle_count=0;
//     'B', 'X', dump_ack in IDLE -> no change.
//   6 reset asserted mid-DRAIN/DUMP -> all outputs 0 asynchronously;
//     saturation: preload near max, RUN -> holds at all-ones.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// Run/step controller for the 5-stage MIPS pipeline.
// It decodes UART command bytes and drives the global pipeline enable and
// flush. On HALT or a break command it drains or freezes the pipe, then
// passes control to the UART debug dumper through a req/ack handshake.
module pipeline_run_ctrl #(
    parameter logic [7:0] CMD_RUN      = 8'h52,
    parameter logic [7:0] CMD_STEP     = 8'h53,
    parameter logic [7:0] CMD_BREAK    = 8'h42,
    parameter logic [7:0] CMD_CLEAR    = 8'h43,
    parameter int         DRAIN_CYCLES = 4,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             halt_fetched,
    input  logic             dump_ack,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             dump_req,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    // The drain counter must hold DRAIN_CYCLES-1.
    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DUMP  = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     drain_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  cycle_cnt_d;

    // The counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Command FSM and drain counter; HALT takes priority over a break in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_RUN)        state_q <= S_RUN;
                        else if (rx_data == CMD_STEP)  state_q <= S_STEP;
                        else if (rx_data == CMD_CLEAR) state_q <= S_FLUSH;
                    end
                end
                S_RUN: begin
                    if (halt_fetched) begin
                        state_q <= S_DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end else if (rx_valid && rx_data == CMD_BREAK) begin
                        state_q <= S_DUMP;
                    end
                end
                S_STEP: begin
                    if (halt_fetched) begin
                        state_q <= S_DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end else begin
                        state_q <= S_DUMP;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) state_q <= S_DUMP;
                    else               drain_q <= drain_q - DW'(1);
                end
                S_DUMP: begin
                    if (dump_ack) state_q <= S_IDLE;
                end
                S_FLUSH: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    assign pipe_en    = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    assign pipe_flush = (state_q == S_FLUSH);
    assign dump_req   = (state_q == S_DUMP);
    assign busy       = (state_q != S_IDLE);
    assign state      = state_q;

    // Next cycle count: cleared by FLUSH, bumped on every enabled clock.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == S_FLUSH) cycle_cnt_d = '0;
        else if (pipe_en)       cycle_cnt_d = sat_inc(cycle_cnt_q);
    end

    // Cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt_q <= '0;
        else       cycle_cnt_q <= cycle_cnt_d;
    end

    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: a cycle model pushes expected outputs to a
// scoreboard as each input cycle is driven; they are popped and compared
// once the DUT has clocked. A second instance with a 4-bit counter covers
// saturation.
module tb_pipeline_run_ctrl;

    localparam logic [7:0] B_R = 8'h52;
    localparam logic [7:0] B_S = 8'h53;
    localparam logic [7:0] B_B = 8'h42;
    localparam logic [7:0] B_C = 8'h43;
    localparam logic [7:0] B_X = 8'h58;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt_fetched;
    logic        dump_ack;
    logic        pipe_en, pipe_flush, dump_req, busy;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic        s_pipe_en, s_pipe_flush, s_dump_req, s_busy;
    logic [2:0]  s_state;
    logic [3:0]  s_cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int pe_seen = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic        pe;
        logic        pf;
        logic        dr;
        logic        bz;
        logic [31:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t sb[$];

    logic [2:0]  m_st;
    int          m_drain;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt_s;

    always #5 clk = ~clk;

    pipeline_run_ctrl dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .halt_fetched(halt_fetched), .dump_ack(dump_ack),
        .pipe_en(pipe_en), .pipe_flush(pipe_flush), .dump_req(dump_req),
        .busy(busy), .state(state), .cycle_count(cycle_count)
    );

    pipeline_run_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .halt_fetched(halt_fetched), .dump_ack(dump_ack),
        .pipe_en(s_pipe_en), .pipe_flush(s_pipe_flush), .dump_req(s_dump_req),
        .busy(s_busy), .state(s_state), .cycle_count(s_cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 3'd0; m_drain = 0; m_cnt = '0; m_cnt_s = '0;
    endtask

    // Reference behaviour for one clock edge given the inputs held across it.
    task automatic model_step(input logic v, input logic [7:0] d, input logic h, input logic a);
        logic pe;
        pe = (m_st == 3'd1) || (m_st == 3'd2) || (m_st == 3'd3);
        if (m_st == 3'd5) begin
            m_cnt = '0; m_cnt_s = '0;
        end else if (pe) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_cnt_s != 4'hF)        m_cnt_s = m_cnt_s + 1;
        end
        case (m_st)
            3'd0: if (v) begin
                      if (d == B_R)      m_st = 3'd1;
                      else if (d == B_S) m_st = 3'd2;
                      else if (d == B_C) m_st = 3'd5;
                  end
            3'd1: if (h) begin m_st = 3'd3; m_drain = 4; end
                  else if (v && d == B_B) m_st = 3'd4;
            3'd2: if (h) begin m_st = 3'd3; m_drain = 4; end
                  else m_st = 3'd4;
            3'd3: begin m_drain--; if (m_drain == 0) m_st = 3'd4; end
            3'd4: if (a) m_st = 3'd0;
            default: m_st = 3'd0;
        endcase
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic h, input logic a);
        exp_t e;
        rx_valid = v; rx_data = d; halt_fetched = h; dump_ack = a;
        model_step(v, d, h, a);
        e.st    = m_st;
        e.pe    = (m_st == 3'd1) || (m_st == 3'd2) || (m_st == 3'd3);
        e.pf    = (m_st == 3'd5);
        e.dr    = (m_st == 3'd4);
        e.bz    = (m_st != 3'd0);
        e.cnt   = m_cnt;
        e.cnt_s = m_cnt_s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("state",       32'(state),         32'(e.st));
        check("pipe_en",     32'(pipe_en),       32'(e.pe));
        check("pipe_flush",  32'(pipe_flush),    32'(e.pf));
        check("dump_req",    32'(dump_req),      32'(e.dr));
        check("busy",        32'(busy),          32'(e.bz));
        check("cycle_count", cycle_count,        e.cnt);
        check("cnt_small",   32'(s_cycle_count), 32'(e.cnt_s));
        pe_seen += int'(pipe_en);
        rx_valid = 1'b0; rx_data = 8'h00; halt_fetched = 1'b0; dump_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic cmd(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic ack();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Assert reset between edges and confirm outputs drop without a clock.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_state"},   32'(state),      32'd0);
        check({tag, "_pipe_en"}, 32'(pipe_en),    32'd0);
        check({tag, "_flush"},   32'(pipe_flush), 32'd0);
        check({tag, "_dumpreq"}, 32'(dump_req),   32'd0);
        check({tag, "_busy"},    32'(busy),       32'd0);
        check({tag, "_cnt"},     cycle_count,     32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        halt_fetched = 1'b0; dump_ack = 1'b0;
        model_reset();
        #3;
        check("rst_state",   32'(state),      32'd0);
        check("rst_pipe_en", 32'(pipe_en),    32'd0);
        check("rst_dumpreq", 32'(dump_req),   32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_cnt",     cycle_count,     32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Single step: one enabled clock, then dump held until ack.
        pe_seen = 0;
        cmd(B_S);
        idle(4);
        check("step_pe_clks", 32'(pe_seen), 32'd1);
        check("step_cnt", cycle_count, 32'd1);
        check("step_dumpreq_held", 32'(dump_req), 32'd1);
        ack();
        check("step_idle", 32'(state), 32'd0);

        // Free run, HALT after 10 run clocks, then 4 drain clocks.
        cmd(B_C); idle(1);
        pe_seen = 0;
        cmd(B_R);
        idle(9);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        check("halt_pe_clks", 32'(pe_seen), 32'd14);
        check("halt_cnt", cycle_count, 32'd14);
        check("halt_dumpreq", 32'(dump_req), 32'd1);
        cmd(B_R);
        ack();
        idle(1);

        // Break after 7 run clocks: straight to DUMP.
        cmd(B_C); idle(1);
        cmd(B_R);
        idle(3);
        cmd(B_S);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);
        cmd(B_B);
        check("break_state", 32'(state), 32'd4);
        check("break_cnt", cycle_count, 32'd7);
        idle(2);
        ack();

        // Halt and break on the same clock: drain wins; drain ignores inputs.
        cmd(B_C); idle(1);
        cmd(B_R);
        idle(2);
        tick(1'b1, B_B, 1'b1, 1'b0);
        check("hb_state", 32'(state), 32'd3);
        pe_seen = 0;
        tick(1'b1, B_B, 1'b1, 1'b0);
        tick(1'b1, B_C, 1'b0, 1'b1);
        idle(2);
        check("hb_drain_clks", 32'(pe_seen), 32'd3);
        check("hb_dump", 32'(state), 32'd4);
        ack();

        // Step into HALT: step clock then full drain.
        cmd(B_S);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);
        check("stephalt_dump", 32'(dump_req), 32'd1);
        ack();

        // Clear after activity; break, unknown byte and ack ignored in IDLE.
        cmd(B_C);
        check("clr_flush", 32'(pipe_flush), 32'd1);
        idle(1);
        check("clr_cnt", cycle_count, 32'd0);
        cmd(B_B);
        cmd(B_X);
        ack();
        check("idle_ignore", 32'(busy), 32'd0);

        // Asynchronous reset in DRAIN and in DUMP.
        cmd(B_R);
        idle(2);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        async_reset("rst_drain");
        cmd(B_R);
        idle(2);
        cmd(B_B);
        async_reset("rst_dump");

        // Saturation: the 4-bit instance pins at 15 while the 32-bit one counts on.
        cmd(B_R);
        idle(20);
        cmd(B_B);
        check("sat_big", cycle_count, 32'd21);
        check("sat_small", 32'(s_cycle_count), 32'd15);
        ack();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
